// File: rtl/lb_arbiter_if.sv
// Local-bus port bundle: one write channel and one read channel.
// The arbiter uses it for each upstream master and for the shared downstream port.
interface lb_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output wen, waddr, wdata, wstrb, ren, raddr,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  wen, waddr, wdata, wstrb, ren, raddr,
        output wready, rdata, rvalid
    );
endinterface

// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter onto one local-bus register port.
// One transaction outstanding; grant held from strobe to wready/rvalid.
module lb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    lb_arbiter_if.slave  m0_if,
    lb_arbiter_if.slave  m1_if,
    lb_arbiter_if.master lb_if
);
    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;

    logic   req0, req1, pick;
    logic   pick_wen;
    logic   in_wr, in_rd;

    logic [ADDR_W-1:0]     waddr_sel;
    logic [ADDR_W-1:0]     raddr_sel;
    logic [DATA_W-1:0]     wdata_sel;
    logic [DATA_W/8-1:0]   wstrb_sel;

    assign req0 = m0_if.wen | m0_if.ren;
    assign req1 = m1_if.wen | m1_if.ren;

    // Tie goes to the master that was not served last.
    assign pick     = (req0 & req1) ? ~last_q : req1;
    assign pick_wen = pick ? m1_if.wen : m0_if.wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = pick;
                    state_d = pick_wen ? WR : RD;
                end
            end
            WR: begin
                if (lb_if.wready) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            RD: begin
                if (lb_if.rvalid) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_wr = (state_q == WR);
    assign in_rd = (state_q == RD);

    assign waddr_sel = gnt_q ? m1_if.waddr : m0_if.waddr;
    assign wdata_sel = gnt_q ? m1_if.wdata : m0_if.wdata;
    assign wstrb_sel = gnt_q ? m1_if.wstrb : m0_if.wstrb;
    assign raddr_sel = gnt_q ? m1_if.raddr : m0_if.raddr;

    // Downstream fields are forced to zero outside their own phase.
    always_comb begin
        lb_if.wen   = 1'b0;
        lb_if.waddr = '0;
        lb_if.wdata = '0;
        lb_if.wstrb = '0;
        lb_if.ren   = 1'b0;
        lb_if.raddr = '0;
        if (in_wr) begin
            lb_if.wen   = 1'b1;
            lb_if.waddr = waddr_sel;
            lb_if.wdata = wdata_sel;
            lb_if.wstrb = wstrb_sel;
        end
        if (in_rd) begin
            lb_if.ren   = 1'b1;
            lb_if.raddr = raddr_sel;
        end
    end

    always_comb begin
        m0_if.wready = 1'b0;
        m1_if.wready = 1'b0;
        m0_if.rvalid = 1'b0;
        m1_if.rvalid = 1'b0;
        m0_if.rdata  = '0;
        m1_if.rdata  = '0;
        if (in_wr && lb_if.wready) begin
            m0_if.wready = ~gnt_q;
            m1_if.wready = gnt_q;
        end
        if (in_rd && lb_if.rvalid) begin
            if (gnt_q) begin
                m1_if.rvalid = 1'b1;
                m1_if.rdata  = lb_if.rdata;
            end else begin
                m0_if.rvalid = 1'b1;
                m0_if.rdata  = lb_if.rdata;
            end
        end
    end
endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter: inputs driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_lb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    lb_arbiter_if m0 ();
    lb_arbiter_if m1 ();
    lb_arbiter_if lb ();

    lb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .m0_if (m0),
        .m1_if (m1),
        .lb_if (lb)
    );

    task automatic clr_inputs();
        m0.wen = 0; m0.waddr = '0; m0.wdata = '0; m0.wstrb = '0;
        m0.ren = 0; m0.raddr = '0;
        m1.wen = 0; m1.waddr = '0; m1.wdata = '0; m1.wstrb = '0;
        m1.ren = 0; m1.raddr = '0;
        lb.wready = 0; lb.rvalid = 0; lb.rdata = '0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 1'b1;
        m0.wen = 1'b1; m0.waddr = 16'h0abc;
        lb.rvalid = 1'b1; lb.rdata = 32'h11223344;
        @(negedge clk); @(negedge clk);
        nchk++; if (lb.wen !== 1'b0) begin nfail++; $display("FAIL rst_lb_wen got=%0h exp=0", lb.wen); end
        nchk++; if (lb.ren !== 1'b0) begin nfail++; $display("FAIL rst_lb_ren got=%0h exp=0", lb.ren); end
        nchk++; if (lb.waddr !== 16'h0) begin nfail++; $display("FAIL rst_lb_waddr got=%0h exp=0", lb.waddr); end
        nchk++; if (m0.rvalid !== 1'b0 || m0.rdata !== 32'h0) begin nfail++; $display("FAIL rst_m0_rd got=%0h/%0h exp=0/0", m0.rvalid, m0.rdata); end
        nchk++; if (m0.wready !== 1'b0) begin nfail++; $display("FAIL rst_m0_wready got=%0h exp=0", m0.wready); end
        clr_inputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [15:0] ea;
        logic [31:0] ed;
        m0.wen = 1; m0.waddr = 16'h000c; m0.wdata = 32'hcafebabe; m0.wstrb = 4'hf;
        m1.wen = 1; m1.waddr = 16'h0010; m1.wdata = 32'h0acce55; m1.wstrb = 4'hf;
        lb.wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ea = (i % 2 == 1) ? 16'h0010 : 16'h000c;
            ed = (i % 2 == 1) ? 32'h0acce55 : 32'hcafebabe;
            @(negedge clk);
            nchk++; if (lb.wen !== 1'b1) begin nfail++; $display("FAIL tie%0d_lb_wen got=%0h exp=1", i, lb.wen); end
            nchk++; if (lb.waddr !== ea || lb.wdata !== ed) begin nfail++; $display("FAIL tie%0d_fields got=%0h/%0h exp=%0h/%0h", i, lb.waddr, lb.wdata, ea, ed); end
            nchk++; if (m0.wready !== (i % 2 == 0) || m1.wready !== (i % 2 == 1)) begin nfail++; $display("FAIL tie%0d_wready got=%0b%0b exp=%0b%0b", i, m1.wready, m0.wready, (i % 2 == 1), (i % 2 == 0)); end
            if (i == 3) begin m0.wen = 0; m1.wen = 0; end
            @(negedge clk);
            nchk++; if (lb.wen !== 1'b0) begin nfail++; $display("FAIL tie%0d_idle got=%0h exp=0", i, lb.wen); end
        end
        @(negedge clk);
        lb.wready = 1'b0;
    endtask

    task automatic test_write();
        m0.wen = 1; m0.waddr = 16'h0004; m0.wdata = 32'hdeadbeef; m0.wstrb = 4'hf;
        m1.waddr = 16'h0bad; m1.wdata = 32'h99999999; m1.wstrb = 4'h3;
        lb.wready = 1'b1;
        @(negedge clk);
        nchk++; if (lb.wen !== 1'b1) begin nfail++; $display("FAIL wr_lb_wen got=%0h exp=1", lb.wen); end
        nchk++; if (lb.waddr !== 16'h0004 || lb.wdata !== 32'hdeadbeef || lb.wstrb !== 4'hf) begin nfail++; $display("FAIL wr_fields got=%0h/%0h/%0h exp=4/deadbeef/f", lb.waddr, lb.wdata, lb.wstrb); end
        nchk++; if (m0.wready !== 1'b1 || m1.wready !== 1'b0) begin nfail++; $display("FAIL wr_wready got=%0b%0b exp=01", m1.wready, m0.wready); end
        m0.wen = 0;
        @(negedge clk);
        nchk++; if (m0.wready !== 1'b0 || lb.wen !== 1'b0 || lb.wdata !== 32'h0) begin nfail++; $display("FAIL wr_after got=%0b/%0b/%0h exp=0/0/0", m0.wready, lb.wen, lb.wdata); end
        lb.wready = 1'b0;
    endtask

    task automatic test_read();
        m1.ren = 1; m1.raddr = 16'h0014;
        m0.raddr = 16'h0777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nchk++; if (lb.ren !== 1'b1 || lb.raddr !== 16'h0014) begin nfail++; $display("FAIL rd_wait%0d got=%0b/%0h exp=1/14", i, lb.ren, lb.raddr); end
            nchk++; if (m1.rvalid !== 1'b0 || m1.rdata !== 32'h0) begin nfail++; $display("FAIL rd_early%0d got=%0b/%0h exp=0/0", i, m1.rvalid, m1.rdata); end
        end
        @(negedge clk);
        lb.rvalid = 1'b1; lb.rdata = 32'hc0debabe;
        #1;
        nchk++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'hc0debabe) begin nfail++; $display("FAIL rd_done got=%0b/%0h exp=1/c0debabe", m1.rvalid, m1.rdata); end
        nchk++; if (m0.rvalid !== 1'b0 || m0.rdata !== 32'h0) begin nfail++; $display("FAIL rd_other got=%0b/%0h exp=0/0", m0.rvalid, m0.rdata); end
        @(negedge clk);
        nchk++; if (m1.rvalid !== 1'b0 || lb.ren !== 1'b0) begin nfail++; $display("FAIL rd_stray got=%0b/%0b exp=0/0", m1.rvalid, lb.ren); end
        m1.ren = 0; lb.rvalid = 1'b0; lb.rdata = '0;
    endtask

    task automatic test_stall();
        m0.wen = 1; m0.waddr = 16'h0020; m0.wdata = 32'h11112222; m0.wstrb = 4'h5;
        lb.wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin m1.ren = 1; m1.raddr = 16'h0030; end
            nchk++; if (lb.wen !== 1'b1 || lb.ren !== 1'b0) begin nfail++; $display("FAIL stall%0d got=%0b/%0b exp=1/0", i, lb.wen, lb.ren); end
            nchk++; if (m0.wready !== 1'b0) begin nfail++; $display("FAIL stall%0d_wready got=%0b exp=0", i, m0.wready); end
        end
        lb.wready = 1'b1;
        #1;
        nchk++; if (m0.wready !== 1'b1 || lb.wstrb !== 4'h5) begin nfail++; $display("FAIL stall_done got=%0b/%0h exp=1/5", m0.wready, lb.wstrb); end
        m0.wen = 0;
        @(negedge clk);
        nchk++; if (lb.ren !== 1'b0 || lb.wen !== 1'b0) begin nfail++; $display("FAIL stall_gap got=%0b/%0b exp=0/0", lb.ren, lb.wen); end
        lb.wready = 1'b0;
        @(negedge clk);
        nchk++; if (lb.ren !== 1'b1 || lb.raddr !== 16'h0030) begin nfail++; $display("FAIL stall_rd got=%0b/%0h exp=1/30", lb.ren, lb.raddr); end
        lb.rvalid = 1'b1; lb.rdata = 32'h55aa55aa;
        #1;
        nchk++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'h55aa55aa || m0.rvalid !== 1'b0) begin nfail++; $display("FAIL stall_rdv got=%0b/%0h/%0b exp=1/55aa55aa/0", m1.rvalid, m1.rdata, m0.rvalid); end
        @(negedge clk);
        m1.ren = 0; lb.rvalid = 1'b0; lb.rdata = '0;
    endtask

    task automatic test_wr_rd();
        m0.wen = 1; m0.waddr = 16'h0040; m0.wdata = 32'h0badf00d; m0.wstrb = 4'hf;
        m0.ren = 1; m0.raddr = 16'h0044;
        lb.wready = 1'b1;
        @(negedge clk);
        nchk++; if (lb.wen !== 1'b1 || lb.ren !== 1'b0 || m0.wready !== 1'b1) begin nfail++; $display("FAIL wrrd_wr got=%0b/%0b/%0b exp=1/0/1", lb.wen, lb.ren, m0.wready); end
        m0.wen = 0;
        @(negedge clk);
        lb.wready = 1'b0;
        lb.rvalid = 1'b1; lb.rdata = 32'hffffffff;
        #1;
        nchk++; if (m0.rvalid !== 1'b0 || m0.rdata !== 32'h0 || lb.ren !== 1'b0) begin nfail++; $display("FAIL wrrd_idle got=%0b/%0h/%0b exp=0/0/0", m0.rvalid, m0.rdata, lb.ren); end
        lb.rvalid = 1'b0; lb.rdata = '0;
        @(negedge clk);
        nchk++; if (lb.ren !== 1'b1 || lb.raddr !== 16'h0044 || m0.rvalid !== 1'b0) begin nfail++; $display("FAIL wrrd_rd got=%0b/%0h/%0b exp=1/44/0", lb.ren, lb.raddr, m0.rvalid); end
        lb.rvalid = 1'b1; lb.rdata = 32'h12345678;
        #1;
        nchk++; if (m0.rvalid !== 1'b1 || m0.rdata !== 32'h12345678 || m1.rdata !== 32'h0) begin nfail++; $display("FAIL wrrd_rdv got=%0b/%0h/%0h exp=1/12345678/0", m0.rvalid, m0.rdata, m1.rdata); end
        @(negedge clk);
        m0.ren = 0; lb.rvalid = 1'b0; lb.rdata = '0;
    endtask

    task automatic test_reset_mid();
        m0.ren = 1; m0.raddr = 16'h0050;
        @(negedge clk);
        nchk++; if (lb.ren !== 1'b1) begin nfail++; $display("FAIL rstm_rd got=%0b exp=1", lb.ren); end
        #2;
        rst = 1'b1;
        lb.rvalid = 1'b1; lb.rdata = 32'hdeaddead;
        #1;
        nchk++; if (lb.ren !== 1'b0 || lb.raddr !== 16'h0) begin nfail++; $display("FAIL rstm_ren got=%0b/%0h exp=0/0", lb.ren, lb.raddr); end
        nchk++; if (m0.rvalid !== 1'b0 || m0.rdata !== 32'h0) begin nfail++; $display("FAIL rstm_rvalid got=%0b/%0h exp=0/0", m0.rvalid, m0.rdata); end
        @(negedge clk);
        clr_inputs();
        rst = 1'b0;
        @(negedge clk);
        m0.wen = 1; m0.waddr = 16'h0060; m0.wdata = 32'ha0a0a0a0; m0.wstrb = 4'hf;
        m1.wen = 1; m1.waddr = 16'h0070; m1.wdata = 32'hb1b1b1b1; m1.wstrb = 4'hf;
        lb.wready = 1'b1;
        @(negedge clk);
        nchk++; if (lb.waddr !== 16'h0060 || m0.wready !== 1'b1 || m1.wready !== 1'b0) begin nfail++; $display("FAIL rstm_tie got=%0h/%0b%0b exp=60/01", lb.waddr, m1.wready, m0.wready); end
        m0.wen = 0; m1.wen = 0;
        @(negedge clk);
        lb.wready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_write();
        test_read();
        test_stall();
        test_wr_rd();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
